// File: rtl/snake_head_ctrl_pkg.sv
// Shared snake game types: direction and FSM encodings, default grid geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snake_head_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_EMIT = 3'd4,
        ST_OVER = 3'd5
    } state_t;

    // Geometry defaults shared with the body stack and the renderer.
    localparam int GRID_W_DEF = 40;
    localparam int GRID_H_DEF = 30;
    localparam int CELL_DEF   = 16;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0, so opposites XOR to 2'b01.
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return ((a ^ b) == 2'b01);
    endfunction

endpackage

// File: rtl/snake_head_ctrl_if.sv
// Segment bus from the head controller to the body stack.
// Latency: n/a (wires only).
// Backpressure: none; the stack must accept every push/pop strobe.
interface snake_head_ctrl_if;
    logic [11:0] posEntX;
    logic [11:0] posEntY;
    logic        push;
    logic        pop;
    logic        eaten;

    modport master (output posEntX, output posEntY, output push, output pop, output eaten);
    modport slave  (input  posEntX, input  posEntY, input  push, input  pop, input  eaten);
endinterface

// File: rtl/snake_head_ctrl_tick_gen.sv
// Game-step divider: counts 0..TICK_DIV-1 while enabled, strobes tick on the last count.
// Latency: tick is combinational from the registered count and the enable.
// Backpressure: disabling holds the count, so a suppressed tick fires once re-enabled.
module snake_tick_gen #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(TICK_DIV - 1));
    assign tick = en && last;

    // Free-running step counter, frozen whenever not enabled.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: tracks head/dir, emits one push (grow) or pop (move) per game step.
// Latency: tick in cycle N -> STEP in N+1 -> push/pop/eaten strobes visible in N+2.
// Backpressure: none; strobes are single-cycle and the body stack must always accept them.
module snake_head_ctrl
    import snake_head_ctrl_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int CELL     = CELL_DEF,
    parameter int TICK_DIV = 5_000_000,
    parameter int START_X  = 20,
    parameter int START_Y  = 15,
    parameter int INIT_LEN = 3,
    parameter int LEN_MAX  = 500,
    parameter int WRAP     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        pause,
    input  logic [11:0] food_x,
    input  logic [11:0] food_y,
    input  logic        food_valid,
    snake_head_ctrl_if.master body,
    output logic        game_over,
    output logic [11:0] head_x,
    output logic [11:0] head_y,
    output logic [9:0]  length,
    output logic [15:0] score
);
    state_t      state;
    dir_t        dir, pending_dir, req;
    logic        req_vld;
    logic [3:0]  btn_s1, btn_s2;      // {up, down, left, right}
    logic [9:0]  k;
    logic [11:0] nx, ny, init_cell;
    logic        off, hit, tick;
    logic [11:0] pos_x, pos_y;
    logic        push_r, pop_r, eaten_r;

    assign body.posEntX = pos_x;
    assign body.posEntY = pos_y;
    assign body.push    = push_r;
    assign body.pop     = pop_r;
    assign body.eaten   = eaten_r;

    function automatic logic [11:0] to_px(input logic [11:0] c);
        return c * 12'(CELL);
    endfunction

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .clr  (reset),
        .en   ((state == ST_RUN) && !pause),
        .tick (tick)
    );

    // Two-flop synchronizer for the raw buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            btn_s1 <= {btn_up, btn_down, btn_left, btn_right};
            btn_s2 <= btn_s1;
        end
    end

    // Highest-priority pressed button: up > down > left > right.
    always_comb begin
        req     = DIR_RIGHT;
        req_vld = 1'b1;
        if      (btn_s2[3]) req = DIR_UP;
        else if (btn_s2[2]) req = DIR_DOWN;
        else if (btn_s2[1]) req = DIR_LEFT;
        else if (btn_s2[0]) req = DIR_RIGHT;
        else                req_vld = 1'b0;
    end

    // Latch the requested direction unless it would reverse the snake onto itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_dir <= DIR_RIGHT;
        end else if (req_vld && !is_opposite(req, dir)) begin
            pending_dir <= req;
        end
    end

    // Next head cell in the pending direction, with wall handling.
    always_comb begin
        nx  = head_x;
        ny  = head_y;
        off = 1'b0;
        case (pending_dir)
            DIR_UP: begin
                if (head_y == 12'd0) begin
                    if (WRAP != 0) ny = 12'(GRID_H - 1);
                    else           off = 1'b1;
                end else ny = head_y - 12'd1;
            end
            DIR_DOWN: begin
                if (head_y == 12'(GRID_H - 1)) begin
                    if (WRAP != 0) ny = 12'd0;
                    else           off = 1'b1;
                end else ny = head_y + 12'd1;
            end
            DIR_LEFT: begin
                if (head_x == 12'd0) begin
                    if (WRAP != 0) nx = 12'(GRID_W - 1);
                    else           off = 1'b1;
                end else nx = head_x - 12'd1;
            end
            default: begin
                if (head_x == 12'(GRID_W - 1)) begin
                    if (WRAP != 0) nx = 12'd0;
                    else           off = 1'b1;
                end else nx = head_x + 12'd1;
            end
        endcase
        hit       = food_valid && (nx == food_x) && (ny == food_y);
        init_cell = 12'(START_X - INIT_LEN + 1) + 12'(k);
    end

    // Game FSM; strobes are set on the STEP edge so they are visible during EMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pos_x     <= '0;
            pos_y     <= '0;
            push_r    <= 1'b0;
            pop_r     <= 1'b0;
            eaten_r   <= 1'b0;
            game_over <= 1'b0;
            head_x    <= 12'(START_X);
            head_y    <= 12'(START_Y);
            dir       <= DIR_RIGHT;
            length    <= '0;
            score     <= '0;
            k         <= '0;
        end else begin
            push_r  <= 1'b0;
            pop_r   <= 1'b0;
            eaten_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|btn_s2) begin
                        state <= ST_INIT;
                        k     <= '0;
                    end
                end
                ST_INIT: begin
                    push_r <= 1'b1;
                    pos_x  <= to_px(init_cell);
                    pos_y  <= to_px(12'(START_Y));
                    length <= length + 10'd1;
                    k      <= k + 10'd1;
                    if (k == 10'(INIT_LEN - 1)) begin
                        state  <= ST_RUN;
                        head_x <= 12'(START_X);
                        head_y <= 12'(START_Y);
                    end
                end
                ST_RUN: begin
                    if (tick) state <= ST_STEP;
                end
                ST_STEP: begin
                    dir <= pending_dir;
                    if (off) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state  <= ST_EMIT;
                        head_x <= nx;
                        head_y <= ny;
                        pos_x  <= to_px(nx);
                        pos_y  <= to_px(ny);
                        if (hit && (length < 10'(LEN_MAX))) begin
                            push_r <= 1'b1;
                            length <= length + 10'd1;
                        end else begin
                            pop_r <= 1'b1;
                        end
                        if (hit) begin
                            eaten_r <= 1'b1;
                            if (score != 16'hFFFF) score <= score + 16'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    state <= ST_RUN;
                end
                ST_OVER: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench: two controllers share stimulus; one with walls (LEN_MAX 500), one wrapping (LEN_MAX 4).
// Latency: n/a.
// Backpressure: n/a.
module tb_snake_head_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        pause = 1'b0;
    logic [11:0] food_x = '0, food_y = '0;
    logic        food_valid = 1'b0;

    logic        go0, go1;
    logic [11:0] hx0, hy0, hx1, hy1;
    logic [9:0]  len0, len1;
    logic [15:0] sc0, sc1;

    int n_tests = 0;
    int n_fail  = 0;

    snake_head_ctrl_if bus0 ();
    snake_head_ctrl_if bus1 ();

    always #5 clk = ~clk;

    snake_head_ctrl #(.TICK_DIV(4), .WRAP(0), .LEN_MAX(500)) dut0 (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pause(pause), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .body(bus0), .game_over(go0), .head_x(hx0), .head_y(hy0), .length(len0), .score(sc0)
    );

    snake_head_ctrl #(.TICK_DIV(4), .WRAP(1), .LEN_MAX(4)) dut1 (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pause(pause), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .body(bus1), .game_over(go1), .head_x(hx1), .head_y(hy1), .length(len1), .score(sc1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until dut0 shows a push or pop; n = cycles advanced.
    task automatic wait_strobe(input string tag, output int n);
        cyc();
        n = 1;
        while (!(bus0.push || bus0.pop) && n < 40) begin
            cyc();
            n++;
        end
        check({tag, "_seen"}, 32'(bus0.push || bus0.pop), 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_push"}, 32'(bus0.push), 0);
        check({tag, "_pop"},  32'(bus0.pop), 0);
        check({tag, "_eat"},  32'(bus0.eaten), 0);
        check({tag, "_go"},   32'(go0), 0);
        check({tag, "_hx"},   32'(hx0), 20);
        check({tag, "_hy"},   32'(hy0), 15);
        check({tag, "_len"},  32'(len0), 0);
        check({tag, "_score"}, 32'(sc0), 0);
        check({tag, "_px"},   32'(bus0.posEntX), 0);
        check({tag, "_py"},   32'(bus0.posEntY), 0);
    endtask

    initial begin
        int n;
        int strobes0, strobes1;
        logic seen1;
        logic [11:0] x1;

        // Reset
        repeat (3) cyc();
        check_reset_state("rst");
        reset = 1'b0;

        // Start: three INIT pushes
        btn_right = 1'b1;
        cyc(); cyc();
        btn_right = 1'b0;
        wait_strobe("init0", n);
        check("init0_push", 32'(bus0.push), 1);
        check("init0_pop",  32'(bus0.pop), 0);
        check("init0_x",    32'(bus0.posEntX), 288);
        check("init0_y",    32'(bus0.posEntY), 240);
        cyc();
        check("init1_push", 32'(bus0.push), 1);
        check("init1_x",    32'(bus0.posEntX), 304);
        cyc();
        check("init2_push", 32'(bus0.push), 1);
        check("init2_x",    32'(bus0.posEntX), 320);
        cyc();
        check("init_done_push", 32'(bus0.push), 0);
        check("init_len",       32'(len0), 3);

        // Move: three pops, no food
        wait_strobe("mv0", n);
        check("mv0_pop",  32'(bus0.pop), 1);
        check("mv0_push", 32'(bus0.push), 0);
        check("mv0_eat",  32'(bus0.eaten), 0);
        check("mv0_x",    32'(bus0.posEntX), 336);
        check("mv0_y",    32'(bus0.posEntY), 240);
        wait_strobe("mv1", n);
        check("mv1_period", 32'(n), 6);
        check("mv1_x",      32'(bus0.posEntX), 352);
        wait_strobe("mv2", n);
        check("mv2_pop", 32'(bus0.pop), 1);
        check("mv2_x",   32'(bus0.posEntX), 368);
        check("mv2_len", 32'(len0), 3);
        check("mv2_hx",  32'(hx0), 23);

        // Eat: food directly ahead
        food_x = 12'd24; food_y = 12'd15; food_valid = 1'b1;
        wait_strobe("eat", n);
        check("eat_push",  32'(bus0.push), 1);
        check("eat_pop",   32'(bus0.pop), 0);
        check("eat_eaten", 32'(bus0.eaten), 1);
        check("eat_x",     32'(bus0.posEntX), 384);
        check("eat_score", 32'(sc0), 1);
        check("eat_len",   32'(len0), 4);
        check("eat1_push", 32'(bus1.push), 1);
        check("eat1_len",  32'(len1), 4);
        food_valid = 1'b0;
        cyc();
        check("eat_eaten_clr", 32'(bus0.eaten), 0);

        // Reversal ignored, then turn up
        btn_left = 1'b1;
        wait_strobe("rev", n);
        check("rev_pop", 32'(bus0.pop), 1);
        check("rev_x",   32'(bus0.posEntX), 400);
        check("rev_y",   32'(bus0.posEntY), 240);
        btn_left = 1'b0;
        btn_up = 1'b1;
        wait_strobe("up", n);
        check("up_pop", 32'(bus0.pop), 1);
        check("up_x",   32'(bus0.posEntX), 400);
        check("up_y",   32'(bus0.posEntY), 224);
        btn_up = 1'b0;

        // Run right to the wall; food at (30,14) hits LEN_MAX on dut1
        btn_right = 1'b1;
        food_x = 12'd30; food_y = 12'd14; food_valid = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            wait_strobe("wall_run", n);
            btn_right = 1'b0;
            check("wall_run_x", 32'(bus0.posEntX), 32'(16 * (25 + i)));
            if (25 + i == 30) begin
                check("full0_push", 32'(bus0.push), 1);
                check("full1_pop",  32'(bus1.pop), 1);
                check("full1_push", 32'(bus1.push), 0);
                check("full1_eat",  32'(bus1.eaten), 1);
            end
        end
        food_valid = 1'b0;
        check("edge_y",    32'(bus0.posEntY), 224);
        check("edge_hx",   32'(hx0), 39);
        check("edge_len0", 32'(len0), 5);
        check("edge_sc0",  32'(sc0), 2);
        check("edge_len1", 32'(len1), 4);
        check("edge_sc1",  32'(sc1), 2);

        // Wall hit: dut0 game over, dut1 wraps to X=0
        strobes0 = 0; seen1 = 1'b0; x1 = 12'hFFF;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus0.push || bus0.pop) strobes0++;
            if (bus1.pop) begin seen1 = 1'b1; x1 = bus1.posEntX; end
        end
        check("wall0_strobes", 32'(strobes0), 0);
        check("wall0_go",      32'(go0), 1);
        check("wrap1_seen",    32'(seen1), 1);
        check("wrap1_x",       32'(x1), 0);
        check("wrap1_go",      32'(go1), 0);

        // Pause: no strobes for 20 cycles, then resume
        pause = 1'b1;
        strobes1 = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus1.push || bus1.pop || bus0.push || bus0.pop) strobes1++;
        end
        check("pause_strobes", 32'(strobes1), 0);
        pause = 1'b0;
        n = 0;
        seen1 = 1'b0;
        while (!seen1 && n < 40) begin
            cyc();
            n++;
            if (bus1.pop) seen1 = 1'b1;
        end
        check("resume_seen", 32'(seen1), 1);
        check("resume_x",    32'(bus1.posEntX), 16);
        check("over_held",   32'(go0), 1);

        // Reset during INIT aborts immediately
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        btn_right = 1'b1;
        cyc(); cyc();
        btn_right = 1'b0;
        wait_strobe("reinit", n);
        check("reinit_push", 32'(bus0.push), 1);
        check("reinit_x",    32'(bus0.posEntX), 288);
        reset = 1'b1;
        cyc();
        check_reset_state("rst_init");
        check("rst_init_len1", 32'(len1), 0);
        reset = 1'b0;
        strobes0 = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus0.push || bus0.pop) strobes0++;
        end
        check("idle_strobes", 32'(strobes0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
